// File: rtl/demux_1to2_reg_pkg.sv
// Shared types for the 1-to-2 registered demux.
// Holds the select encoding and the destination decode helper.
package demux_1to2_reg_pkg;

  localparam logic SEL_B = 1'b0;
  localparam logic SEL_C = 1'b1;

  typedef enum logic [1:0] {
    PORT_NONE = 2'b00,
    PORT_B    = 2'b01,
    PORT_C    = 2'b10
  } port_e;

  // Select is only looked at when the word is valid,
  // so an undriven Select on an idle cycle is harmless.
  function automatic port_e dest(
    input logic vld,
    input logic sel
  );
    port_e p;
    p = PORT_NONE;
    unique case (1'b1)
      !vld:                 p = PORT_NONE;
      vld && sel == SEL_B:  p = PORT_B;
      vld && sel == SEL_C:  p = PORT_C;
      default:              p = PORT_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/demux_1to2_reg_if.sv
// Producer/consumer bundle for demux_1to2_reg.
// master drives the input word, slave is the demux itself.
interface demux_1to2_reg_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] A;
  logic                  Select;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] B;
  logic [DATA_WIDTH-1:0] C;
  logic                  B_valid;
  logic                  C_valid;

  modport master (
    output A,
    output Select,
    output in_valid,
    input  B,
    input  C,
    input  B_valid,
    input  C_valid
  );

  modport slave (
    input  A,
    input  Select,
    input  in_valid,
    output B,
    output C,
    output B_valid,
    output C_valid
  );

endinterface

// File: rtl/demux_1to2_reg_route.sv
// Combinational routing: next-state for the demux output registers.
// Kept standalone so a purely combinational demux can reuse it.
module demux_1to2_reg_route
  import demux_1to2_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic                  sel,
  input  logic                  vld,
  input  logic [DATA_WIDTH-1:0] b_q,
  input  logic [DATA_WIDTH-1:0] c_q,
  output logic [DATA_WIDTH-1:0] b_d,
  output logic [DATA_WIDTH-1:0] c_d,
  output logic                  b_vld_d,
  output logic                  c_vld_d
);

  port_e port;

  assign port = dest(vld, sel);

  always_comb begin
    b_d     = b_q;
    c_d     = c_q;
    b_vld_d = 1'b0;
    c_vld_d = 1'b0;
    unique case (port)
      PORT_B: begin
        b_d     = a;
        c_d     = '0;
        b_vld_d = 1'b1;
      end
      PORT_C: begin
        b_d     = '0;
        c_d     = a;
        c_vld_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/demux_1to2_reg.sv
// 1-to-2 demux with registered outputs and per-port valids.
// Unselected port is zeroed on every accept; idle cycles hold data.
module demux_1to2_reg #(
  parameter int DATA_WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  demux_1to2_reg_if.slave bus
);

  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] c_q;
  logic                  b_vld_q;
  logic                  c_vld_q;

  logic [DATA_WIDTH-1:0] b_d;
  logic [DATA_WIDTH-1:0] c_d;
  logic                  b_vld_d;
  logic                  c_vld_d;

  demux_1to2_reg_route #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_route (
    .a       (bus.A),
    .sel     (bus.Select),
    .vld     (bus.in_valid),
    .b_q     (b_q),
    .c_q     (c_q),
    .b_d     (b_d),
    .c_d     (c_d),
    .b_vld_d (b_vld_d),
    .c_vld_d (c_vld_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q     <= '0;
      c_q     <= '0;
      b_vld_q <= 1'b0;
      c_vld_q <= 1'b0;
    end else begin
      b_q     <= b_d;
      c_q     <= c_d;
      b_vld_q <= b_vld_d;
      c_vld_q <= c_vld_d;
    end
  end

  assign bus.B       = b_q;
  assign bus.C       = c_q;
  assign bus.B_valid = b_vld_q;
  assign bus.C_valid = c_vld_q;

  a_vld_onehot0 : assert property (
    @(posedge clk) disable iff (rst)
    !(b_vld_q && c_vld_q)
  );

  a_b_zeroes_c : assert property (
    @(posedge clk) disable iff (rst)
    b_vld_q |-> (c_q == '0)
  );

  a_c_zeroes_b : assert property (
    @(posedge clk) disable iff (rst)
    c_vld_q |-> (b_q == '0)
  );

endmodule

// File: tb/tb_demux_1to2_reg.sv
// Directed bench for demux_1to2_reg at DATA_WIDTH 2 and 8.
module tb_demux_1to2_reg;

  logic clk;
  logic rst;

  int n_vec;
  int n_bad;

  demux_1to2_reg_if #(.DATA_WIDTH(2)) if2 ();
  demux_1to2_reg_if #(.DATA_WIDTH(8)) if8 ();

  demux_1to2_reg #(.DATA_WIDTH(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2.slave)
  );

  demux_1to2_reg #(.DATA_WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic [1:0] a;
    logic       sel;
    logic       vld;
    logic [1:0] b;
    logic [1:0] c;
    logic       bv;
    logic       cv;
  } vec_t;

  vec_t tbl [12];

  task automatic check(
    input string       name,
    input logic [17:0] act,
    input logic [17:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {B,C,Bv,Cv}=%h want %h",
               name, act, exp);
    end
  endtask

  function automatic logic [17:0] obs2();
    return {10'b0, if2.B, if2.C, if2.B_valid, if2.C_valid};
  endfunction

  function automatic logic [17:0] obs8();
    return {if8.B, if8.C, if8.B_valid, if8.C_valid};
  endfunction

  task automatic drive2(input logic [1:0] a, input logic s,
                        input logic v);
    if2.A = a;
    if2.Select = s;
    if2.in_valid = v;
  endtask

  task automatic drive8(input logic [7:0] a, input logic s,
                        input logic v);
    if8.A = a;
    if8.Select = s;
    if8.in_valid = v;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    //          rst  a      sel   vld   b      c      bv    cv
    tbl[0]  = '{1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'b10, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 2'b01, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 2'b11, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 2'b11, 1'b0, 1'b1, 2'b11, 2'b00, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 2'bxx, 1'bx, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 2'b11, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b1};

    rst = 1'b1;
    drive2(2'b11, 1'b0, 1'b1);
    drive8(8'hFF, 1'b1, 1'b1);
    #1;
    check("reset2", obs2(), 18'h0);
    check("reset8", obs8(), 18'h0);
    drive8(8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      drive2(tbl[i].a, tbl[i].sel, tbl[i].vld);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), obs2(),
            {10'b0, tbl[i].b, tbl[i].c, tbl[i].bv, tbl[i].cv});
    end
    check("idle8", obs8(), 18'h0);

    // back-to-back traffic on both widths, ports alternating
    @(negedge clk);
    drive2(2'b01, 1'b0, 1'b1);
    drive8(8'hA5, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("b2b2_a", obs2(), {10'b0, 2'b01, 2'b00, 1'b1, 1'b0});
    check("b2b8_a", obs8(), {8'h00, 8'hA5, 1'b0, 1'b1});
    @(negedge clk);
    drive2(2'b01, 1'b1, 1'b1);
    drive8(8'h5A, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("b2b2_b", obs2(), {10'b0, 2'b00, 2'b01, 1'b0, 1'b1});
    check("b2b8_b", obs8(), {8'h5A, 8'h00, 1'b1, 1'b0});

    // async reset between edges, inputs still valid
    #2;
    drive2(2'b11, 1'b0, 1'b1);
    drive8(8'hC3, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    check("async2", obs2(), 18'h0);
    check("async8", obs8(), 18'h0);
    @(posedge clk);
    #1;
    check("rsthold2", obs2(), 18'h0);
    check("rsthold8", obs8(), 18'h0);

    @(negedge clk);
    rst = 1'b0;
    drive2(2'b10, 1'b1, 1'b1);
    drive8(8'hA5, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("post2", obs2(), {10'b0, 2'b00, 2'b10, 1'b0, 1'b1});
    check("post8", obs8(), {8'hA5, 8'h00, 1'b1, 1'b0});

    @(negedge clk);
    drive2(2'bxx, 1'bx, 1'b0);
    drive8(8'hxx, 1'bx, 1'b0);
    @(posedge clk);
    #1;
    check("hold2", obs2(), {10'b0, 2'b00, 2'b10, 1'b0, 1'b0});
    check("hold8", obs8(), {8'hA5, 8'h00, 1'b0, 1'b0});

    @(negedge clk);
    drive8(8'hA5, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("swap8", obs8(), {8'h00, 8'hA5, 1'b0, 1'b1});

    @(negedge clk);
    drive2(2'b00, 1'b0, 1'b0);
    drive8(8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("drop8", obs8(), {8'h00, 8'hA5, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
